// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetch requests under a
// credit limit, tracks the addresses of outstanding requests, buffers the
// returning instruction words and presents the buffer head to IF/ID.
// Taken branches discard both the buffer and any responses still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
    localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
    localparam logic [CW-1:0] C_ONE   = 1;
    localparam logic [PW-1:0] P_ONE   = 1;

    // Control state
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_buf_cnt;
    logic [PW-1:0] r_af_wr, r_af_rd;
    logic [PW-1:0] r_bf_wr, r_bf_rd;

    // Storage: address FIFO and fetch buffer
    logic [31:0]   r_af_mem   [DEPTH];
    logic [31:0]   r_bf_instr [DEPTH];
    logic [31:0]   r_bf_pc4   [DEPTH];

    logic [CW:0]   w_credit_used;
    logic          w_req_fire;
    logic          w_rsp;
    logic          w_rsp_drop;
    logic          w_rsp_live;
    logic          w_buf_push;
    logic          w_buf_pop;
    logic          w_buf_nonempty;
    logic [31:0]   w_redirect_pc;
    logic [CW-1:0] w_rsp_dec;

    // Buffered entries count against the credit as well, so a stalled
    // consumer can never cause the buffer to overflow.
    assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, r_buf_cnt};
    assign imem_req_valid = !reset && !redirect && (w_credit_used < DEPTH_W);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A beat with nothing outstanding cannot be ours; ignoring it keeps the
    // counters from underflowing.
    assign w_rsp          = imem_rsp_valid && !reset && (r_outstanding != '0);
    assign w_rsp_drop     = w_rsp && (r_drop_cnt != '0);
    assign w_rsp_live     = w_rsp && (r_drop_cnt == '0);
    assign w_rsp_dec      = w_rsp ? C_ONE : '0;

    assign w_buf_nonempty = (r_buf_cnt != '0);
    assign w_buf_push     = w_rsp_live && !redirect;
    assign w_buf_pop      = w_buf_nonempty && !stall && !redirect;

    assign w_redirect_pc  = redirect_pc & 32'hFFFF_FFFC;

    // Buffer head is shown combinationally; an empty buffer reads as a NOP
    // so IF/ID latches a bubble.
    assign if_valid = w_buf_nonempty;
    assign if_instr = w_buf_nonempty ? r_bf_instr[r_bf_rd] : '0;
    assign if_pc4   = w_buf_nonempty ? r_bf_pc4[r_bf_rd]   : '0;

    // Fetch PC, credit counters and FIFO pointers; redirect overrides all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_buf_cnt     <= '0;
            r_af_wr       <= '0;
            r_af_rd       <= '0;
            r_bf_wr       <= '0;
            r_bf_rd       <= '0;
        end else begin
            // No request issues in a redirect cycle, so only the response
            // can change the outstanding count there.
            case ({w_req_fire, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + C_ONE;
                2'b01:   r_outstanding <= r_outstanding - C_ONE;
                default: r_outstanding <= r_outstanding;
            endcase

            if (redirect) begin
                // Everything still in flight after this cycle is stale.
                r_fetch_pc <= w_redirect_pc;
                r_drop_cnt <= r_outstanding - w_rsp_dec;
                r_buf_cnt  <= '0;
                r_af_wr    <= '0;
                r_af_rd    <= '0;
                r_bf_wr    <= '0;
                r_bf_rd    <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_af_wr    <= r_af_wr + P_ONE;
                end
                if (w_rsp_drop)
                    r_drop_cnt <= r_drop_cnt - C_ONE;
                if (w_rsp_live)
                    r_af_rd <= r_af_rd + P_ONE;
                if (w_buf_push)
                    r_bf_wr <= r_bf_wr + P_ONE;
                if (w_buf_pop)
                    r_bf_rd <= r_bf_rd + P_ONE;
                case ({w_buf_push, w_buf_pop})
                    2'b10:   r_buf_cnt <= r_buf_cnt + C_ONE;
                    2'b01:   r_buf_cnt <= r_buf_cnt - C_ONE;
                    default: r_buf_cnt <= r_buf_cnt;
                endcase
            end
        end
    end

    // Data storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (w_req_fire)
            r_af_mem[r_af_wr] <= r_fetch_pc;
        if (w_buf_push) begin
            r_bf_instr[r_bf_wr] <= imem_rsp_data;
            r_bf_pc4[r_bf_wr]   <= r_af_mem[r_af_rd] + 32'd4;
        end
    end

    a_no_buf_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_buf_push && !w_buf_pop && (r_buf_cnt == DEPTH_C)));

    a_cnt_bounds: assert property (@(posedge clk) disable iff (reset)
        (r_outstanding <= DEPTH_C) && (r_drop_cnt <= r_outstanding) && (r_buf_cnt <= DEPTH_C));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory model that echoes the
// request address as data, and an IF/ID consumer that logs every
// instruction popped from the fetch buffer.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;

    int ncmp = 0;
    int nbad = 0;

    logic [31:0] pend_addr[$];
    logic        mem_hold = 1'b0;
    logic [31:0] got_instr[$];
    logic [31:0] got_pc4[$];
    int          req_cnt = 0;
    logic [31:0] last_req = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid)
    );

    // Memory model bookkeeping and consumer log, sampled at the active edge.
    always @(posedge clk) begin
        if (reset) begin
            pend_addr.delete();
        end else begin
            if (imem_rsp_valid && pend_addr.size() > 0)
                void'(pend_addr.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                req_cnt++;
                last_req = imem_req_addr;
            end
            if (if_valid && !stall && !redirect) begin
                got_instr.push_back(if_instr);
                got_pc4.push_back(if_pc4);
            end
        end
    end

    // One-cycle memory: oldest accepted address returned as data.
    always @(negedge clk) begin
        if (!mem_hold && pend_addr.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_addr[0];
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    task automatic test_reset;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        ncmp++; if (imem_req_valid !== 1'b0) begin nbad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        ncmp++; if (if_valid !== 1'b0) begin nbad++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
        ncmp++; if (if_instr !== 32'h0) begin nbad++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
        ncmp++; if (if_pc4 !== 32'h0) begin nbad++; $display("FAIL rst_if_pc4: got %h want 0", if_pc4); end
        reset = 1'b0;
        #1;
        ncmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin nbad++; $display("FAIL first_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
        @(negedge clk); #1;
        ncmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin nbad++; $display("FAIL no_bypass: got v=%b i=%h want v=0 i=0", if_valid, if_instr); end
        @(negedge clk); #1;
        ncmp++; if (if_valid !== 1'b1 || if_instr !== 32'h0 || if_pc4 !== 32'h4) begin nbad++; $display("FAIL first_instr: got v=%b i=%h p=%h want v=1 i=0 p=4", if_valid, if_instr, if_pc4); end
    endtask

    task automatic test_stream;
        repeat (30) @(negedge clk);
        ncmp++; if (got_instr.size() < 8) begin nbad++; $display("FAIL stream_count: got %0d want >=8", got_instr.size()); end
        for (int i = 0; i < 8 && i < got_instr.size(); i++) begin
            ncmp++;
            if (got_instr[i] !== 32'(4*i) || got_pc4[i] !== 32'(4*i+4)) begin
                nbad++; $display("FAIL stream[%0d]: got %h/%h want %h/%h", i, got_instr[i], got_pc4[i], 32'(4*i), 32'(4*i+4));
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] held;
        int n0;
        bit  seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (if_valid) seen = 1'b1;
        end
        ncmp++; if (!seen) begin nbad++; $display("FAIL stall_wait: got if_valid=0 want 1 within 20 cycles"); end
        stall = 1'b1;
        held = 32'(4*got_instr.size());
        n0 = got_instr.size();
        ncmp++; if (if_instr !== held) begin nbad++; $display("FAIL stall_head: got %h want %h", if_instr, held); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ncmp++; if (if_valid !== 1'b1 || if_instr !== held || if_pc4 !== held + 32'd4) begin nbad++; $display("FAIL stall_hold[%0d]: got v=%b i=%h p=%h want v=1 i=%h", k, if_valid, if_instr, if_pc4, held); end
            ncmp++; if (req_cnt - got_instr.size() > 2) begin nbad++; $display("FAIL stall_credit[%0d]: got %0d in flight+buffered want <=2", k, req_cnt - got_instr.size()); end
        end
        ncmp++; if (got_instr.size() != n0) begin nbad++; $display("FAIL stall_nopop: got %0d entries want %0d", got_instr.size(), n0); end
        stall = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < got_instr.size(); i++) begin
            ncmp++;
            if (got_instr[i] !== 32'(4*i) || got_pc4[i] !== 32'(4*i+4)) begin
                nbad++; $display("FAIL stall_seq[%0d]: got %h/%h want %h/%h", i, got_instr[i], got_pc4[i], 32'(4*i), 32'(4*i+4));
            end
        end
    endtask

    task automatic test_redirect;
        logic [31:0] e;
        mem_hold = 1'b1;
        repeat (6) @(negedge clk);
        ncmp++; if (pend_addr.size() != 2 || if_valid !== 1'b0) begin nbad++; $display("FAIL redir_setup: got pend=%0d v=%b want pend=2 v=0", pend_addr.size(), if_valid); end
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        ncmp++; if (imem_req_valid !== 1'b0) begin nbad++; $display("FAIL redir_noreq: got %b want 0", imem_req_valid); end
        @(negedge clk);
        redirect = 1'b0; mem_hold = 1'b0;
        got_instr.delete(); got_pc4.delete();
        repeat (15) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e = 32'h100 + 32'(4*i);
            ncmp++;
            if (got_instr.size() <= i) begin nbad++; $display("FAIL redir[%0d]: got none want %h", i, e); end
            else if (got_instr[i] !== e || got_pc4[i] !== e + 32'd4) begin nbad++; $display("FAIL redir[%0d]: got %h/%h want %h/%h", i, got_instr[i], got_pc4[i], e, e + 32'd4); end
        end
    endtask

    task automatic test_misaligned;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h203;
        @(negedge clk);
        redirect = 1'b0;
        got_instr.delete(); got_pc4.delete();
        ncmp++; if (imem_req_addr !== 32'h200) begin nbad++; $display("FAIL misalign_addr: got %h want 00000200", imem_req_addr); end
        repeat (15) @(negedge clk);
        ncmp++;
        if (got_instr.size() < 1) begin nbad++; $display("FAIL misalign_instr: got none want 00000200"); end
        else if (got_instr[0] !== 32'h200 || got_pc4[0] !== 32'h204) begin nbad++; $display("FAIL misalign_instr: got %h/%h want 00000200/00000204", got_instr[0], got_pc4[0]); end
    endtask

    task automatic test_wrap;
        logic [31:0] e;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        got_instr.delete(); got_pc4.delete();
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = 32'hFFFF_FFF8 + 32'(4*i);
            ncmp++;
            if (got_instr.size() <= i) begin nbad++; $display("FAIL wrap[%0d]: got none want %h", i, e); end
            else if (got_instr[i] !== e || got_pc4[i] !== e + 32'd4) begin nbad++; $display("FAIL wrap[%0d]: got %h/%h want %h/%h", i, got_instr[i], got_pc4[i], e, e + 32'd4); end
        end
    endtask

    task automatic test_redirect_rsp;
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #1;
            if (imem_rsp_valid) seen = 1'b1;
        end
        ncmp++; if (!seen) begin nbad++; $display("FAIL rsp_wait: got no response want one within 20 cycles"); end
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect = 1'b0;
        got_instr.delete(); got_pc4.delete();
        ncmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc4 !== 32'h0) begin nbad++; $display("FAIL rsp_redir_bubble: got v=%b i=%h p=%h want 0/0/0", if_valid, if_instr, if_pc4); end
        repeat (15) @(negedge clk);
        ncmp++;
        if (got_instr.size() < 1) begin nbad++; $display("FAIL rsp_redir_next: got none want 00000300"); end
        else if (got_instr[0] !== 32'h300 || got_pc4[0] !== 32'h304) begin nbad++; $display("FAIL rsp_redir_next: got %h/%h want 00000300/00000304", got_instr[0], got_pc4[0]); end
    endtask

    task automatic test_ready_low;
        logic [31:0] exp_addr;
        @(negedge clk);
        imem_req_ready = 1'b0;
        repeat (5) @(negedge clk);
        exp_addr = last_req + 32'd4;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ncmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc4 !== 32'h0) begin nbad++; $display("FAIL rdy_low_out[%0d]: got v=%b i=%h p=%h want 0/0/0", k, if_valid, if_instr, if_pc4); end
            ncmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr) begin nbad++; $display("FAIL rdy_low_req[%0d]: got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, exp_addr); end
        end
        imem_req_ready = 1'b1;
        got_instr.delete(); got_pc4.delete();
        repeat (10) @(negedge clk);
        ncmp++;
        if (got_instr.size() < 1) begin nbad++; $display("FAIL rdy_resume: got none want %h", exp_addr); end
        else if (got_instr[0] !== exp_addr) begin nbad++; $display("FAIL rdy_resume: got %h want %h", got_instr[0], exp_addr); end
    endtask

    task automatic test_midreset;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        ncmp++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || imem_req_valid !== 1'b0) begin nbad++; $display("FAIL midrst_async: got v=%b i=%h rv=%b want 0/0/0", if_valid, if_instr, imem_req_valid); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        got_instr.delete(); got_pc4.delete();
        repeat (15) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ncmp++;
            if (got_instr.size() <= i) begin nbad++; $display("FAIL midrst[%0d]: got none want %h", i, 32'(4*i)); end
            else if (got_instr[i] !== 32'(4*i) || got_pc4[i] !== 32'(4*i+4)) begin nbad++; $display("FAIL midrst[%0d]: got %h/%h want %h/%h", i, got_instr[i], got_pc4[i], 32'(4*i), 32'(4*i+4)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_redirect_rsp();
        test_ready_low();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, is the fetch buffer depth and the outstanding-request cap; legal values are 2 and 4.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high; clock is clk.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_req_ready  input  1  memory accepts request; transfer occurs when valid and ready are both 1.
REQ-008 imem_rsp_valid  input  1  response beat; responses are in order with at least 1 cycle latency.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 stall  input  1  downstream hold, the same signal that holds the IF/ID register.
REQ-011 redirect  input  1  taken branch or jump; restart fetch.
REQ-012 redirect_pc  input  32  new fetch address.
REQ-013 if_instr  output  32  instruction toward IF/ID.
REQ-014 if_pc4  output  32  address of if_instr plus 4.
REQ-015 if_valid  output  1  if_instr and if_pc4 are meaningful.

Function
REQ-016 Internal fetch_pc holds the next request address; imem_req_addr SHALL equal fetch_pc.
REQ-017 imem_req_valid SHALL be 1 only when (outstanding + buffer occupancy) < DEPTH and redirect is 0.
REQ-018 On an accepted request, fetch_pc SHALL advance by 4 (32-bit wrap from FFFF_FFFC to 0000_0000), the address SHALL be pushed to an address FIFO, and outstanding SHALL increment.
REQ-019 Each non-discarded response SHALL pop the address FIFO and push {imem_rsp_data, addr+4} into the fetch buffer, and outstanding SHALL decrement.
REQ-020 if_valid SHALL be 1 when the buffer is non-empty; if_instr/if_pc4 SHALL then show the buffer head combinationally.
REQ-021 When the buffer is empty, if_instr and if_pc4 SHALL both be 32'h0 (NOP), so that the IF/ID register latches a bubble.
REQ-022 The buffer head SHALL pop when if_valid=1 and stall=0; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 A response arriving while the buffer is empty and stall=0 SHALL appear on the outputs no earlier than the next cycle (registered buffer; no bypass).
REQ-024 On redirect=1: fetch_pc <= {redirect_pc[31:2],2'b00}; the buffer and address FIFO SHALL clear; drop_cnt <= outstanding minus any response accepted in that same cycle; no request SHALL issue that cycle.
REQ-025 While drop_cnt>0, each response SHALL be discarded, decrementing drop_cnt and outstanding, and SHALL never enter the buffer.
REQ-026 Redirect SHALL take priority over a simultaneous response push, buffer pop, and request issue.
REQ-027 Back-to-back redirects SHALL each reload fetch_pc; drop_cnt SHALL always equal the in-flight responses that are stale.
REQ-028 Stall SHALL NOT block requests or responses; the credit check in REQ-017 alone prevents overflow. Buffer overflow is unreachable and SHALL be flagged by an assertion.
REQ-029 Counters are log2(DEPTH)+1 bits wide and SHALL never exceed DEPTH or underflow.

Reset
REQ-030 On reset: fetch_pc=RESET_PC, buffer and address FIFO empty, outstanding=0, drop_cnt=0, imem_req_valid=0, if_valid=0, if_instr=0, if_pc4=0.
REQ-031 Reset asserted mid-operation SHALL abandon all in-flight requests; responses arriving while reset is high SHALL be ignored.
REQ-032 The first request SHALL be issued in the first cycle after reset deasserts, provided imem_req_ready=1.

Verification
REQ-033 Reset release, ready=1, 1-cycle memory returning addr as data, stall=0 -> requests 0x0,0x4,0x8...; if_instr 0x0,0x4,... with if_pc4 0x4,0x8,...
REQ-034 stall=1 for 5 cycles during streaming -> outputs hold one instruction, at most DEPTH requests outstanding plus buffered, no instruction lost or duplicated after release.
REQ-035 Redirect to 0x100 with 2 responses in flight -> both stale responses dropped; next if_instr is from 0x100 with if_pc4=0x104.
REQ-036 redirect_pc=0x203 -> fetch resumes at 0x200.
REQ-037 Redirect in the same cycle as a response and stall=0 -> the response is discarded, buffer empty, outputs 0 next cycle.
REQ-038 imem_req_ready held 0 for 10 cycles -> if_valid=0 with outputs 0; imem_req_addr stable at the unaccepted fetch address.
